// File: rtl/hbridge_driver.sv
// hbridge_driver: H-bridge input driver with dead-time insertion between opposing drive states
module hbridge_driver #(
   parameter int DEADTIME = 50
) (
   input  logic       HBRIDGE_DRIVER_CLOCK_50,
   input  logic       HBRIDGE_DRIVER_RESET_InLow,
   input  logic [1:0] HBRIDGE_DRIVER_CONTROL_InBus,
   input  logic       HBRIDGE_DRIVER_PWM_In,
   output logic       HBRIDGE_DRIVER_IN1_Out,
   output logic       HBRIDGE_DRIVER_IN2_Out,
   output logic       HBRIDGE_DRIVER_BUSY_Out,
   output logic [2:0] HBRIDGE_DRIVER_STATE_OutBus
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FWD   = 3'd1,
      REV   = 3'd2,
      BRAKE = 3'd3,
      DEAD  = 3'd4
   } state_t;
   state_t     state, state_nx, target;
   logic [1:0] cmd_q;
   logic [7:0] cnt, cnt_nx;
   assign target = state_t'({1'b0, cmd_q});
   assign HBRIDGE_DRIVER_BUSY_Out = state == DEAD;
   assign HBRIDGE_DRIVER_STATE_OutBus = state;
   // state, command and dead-time counter registers
   always_ff @(posedge HBRIDGE_DRIVER_CLOCK_50 or negedge HBRIDGE_DRIVER_RESET_InLow)
      if (!HBRIDGE_DRIVER_RESET_InLow) begin
         state <= IDLE;
         cmd_q <= 2'b00;
         cnt   <= 8'd0;
      end else begin
         state <= state_nx;
         cmd_q <= HBRIDGE_DRIVER_CONTROL_InBus;
         cnt   <= cnt_nx;
      end
   // next state: direct moves to/from IDLE, DEAD between any two driven states
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: state_nx = target;
         FWD, REV, BRAKE:
            if (target != state) begin
               state_nx = (cmd_q == 2'b00) ? IDLE : DEAD;
               cnt_nx   = 8'd0;
            end
         DEAD:
            if (cnt == 8'(DEADTIME - 1)) state_nx = target;
            else cnt_nx = cnt + 8'd1;
         default: state_nx = IDLE;
      endcase
   end
   // registered bridge inputs; only BRAKE drives both high, unknown codes drive 0/0
   always_ff @(posedge HBRIDGE_DRIVER_CLOCK_50 or negedge HBRIDGE_DRIVER_RESET_InLow)
      if (!HBRIDGE_DRIVER_RESET_InLow) begin
         HBRIDGE_DRIVER_IN1_Out <= 1'b0;
         HBRIDGE_DRIVER_IN2_Out <= 1'b0;
      end else begin
         HBRIDGE_DRIVER_IN1_Out <= (state == FWD && HBRIDGE_DRIVER_PWM_In) || state == BRAKE;
         HBRIDGE_DRIVER_IN2_Out <= (state == REV && HBRIDGE_DRIVER_PWM_In) || state == BRAKE;
      end
endmodule
